// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between register-read, the execute unit and writeback.
// The master drives requests and consumes results; the slave is the execute unit.
interface alu_exec_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_op;
  logic [2:0]      funct3;
  logic            funct7_5;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  modport master (
    output in_valid, alu_op, funct3, funct7_5, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, alu_op, funct3, funct7_5, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Multi-cycle execute unit: ALU-control decode plus datapath ALU behind valid/ready,
// with optional bit-serial shifting (one shift position per cycle).
module alu_exec_unit #(
  parameter int XLEN         = 32,
  parameter int SHIFT_SERIAL = 1
) (
  input logic           clk,
  input logic           rst_n,
  alu_exec_unit_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
  } aluOp_t;

  state_t          r_state;
  logic            r_inReady;
  logic            r_outValid;
  logic [XLEN-1:0] r_result;
  logic            r_illegal;
  logic            r_hasResult;
  logic [XLEN-1:0] r_shiftReg;
  logic [SHW-1:0]  r_count;
  aluOp_t          r_shiftOp;

  aluOp_t          w_op;
  logic            w_illegal;
  logic            w_isShift;
  logic            w_accept;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_aluResult;
  logic [XLEN-1:0] w_shiftStep;

  assign w_shamt  = bus.op_b[SHW-1:0];
  assign w_accept = bus.in_valid && r_inReady;
  assign w_isShift = (w_op == OP_SLL) || (w_op == OP_SRL) || (w_op == OP_SRA);

  // ALU control: alu_op selects add/sub directly or defers to funct3/funct7_5
  always_comb begin
    w_op      = OP_ADD;
    w_illegal = 1'b0;
    case (bus.alu_op)
      2'b00: w_op = OP_ADD;
      2'b01: w_op = OP_SUB;
      2'b10: begin
        case (bus.funct3)
          3'b000:  w_op = bus.funct7_5 ? OP_SUB : OP_ADD;
          3'b001:  w_op = OP_SLL;
          3'b010:  w_op = OP_SLT;
          3'b011:  w_op = OP_SLTU;
          3'b100:  w_op = OP_XOR;
          3'b101:  w_op = bus.funct7_5 ? OP_SRA : OP_SRL;
          3'b110:  w_op = OP_OR;
          default: w_op = OP_AND;
        endcase
        if (bus.funct7_5 && (bus.funct3 != 3'b000) && (bus.funct3 != 3'b101)) begin
          w_illegal = 1'b1;
        end
      end
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_aluResult = '0;
    case (w_op)
      OP_ADD:  w_aluResult = bus.op_a + bus.op_b;
      OP_SUB:  w_aluResult = bus.op_a - bus.op_b;
      OP_SLL:  w_aluResult = bus.op_a << w_shamt;
      OP_SLT:  w_aluResult = {{(XLEN-1){1'b0}}, $signed(bus.op_a) < $signed(bus.op_b)};
      OP_SLTU: w_aluResult = {{(XLEN-1){1'b0}}, bus.op_a < bus.op_b};
      OP_XOR:  w_aluResult = bus.op_a ^ bus.op_b;
      OP_SRL:  w_aluResult = bus.op_a >> w_shamt;
      OP_SRA:  w_aluResult = $unsigned($signed(bus.op_a) >>> w_shamt);
      OP_OR:   w_aluResult = bus.op_a | bus.op_b;
      OP_AND:  w_aluResult = bus.op_a & bus.op_b;
      default: w_aluResult = '0;
    endcase
  end

  always_comb begin
    w_shiftStep = {1'b0, r_shiftReg[XLEN-1:1]};
    case (r_shiftOp)
      OP_SLL:  w_shiftStep = {r_shiftReg[XLEN-2:0], 1'b0};
      OP_SRA:  w_shiftStep = {r_shiftReg[XLEN-1], r_shiftReg[XLEN-1:1]};
      default: w_shiftStep = {1'b0, r_shiftReg[XLEN-1:1]};
    endcase
  end

  // Control FSM; in_ready stays low during reset and rises on the first clock after
  // release. A zero shift amount skips the SHIFT state since the ALU already yields op_a.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_inReady   <= 1'b0;
      r_outValid  <= 1'b0;
      r_result    <= '0;
      r_illegal   <= 1'b0;
      r_hasResult <= 1'b0;
      r_shiftReg  <= '0;
      r_count     <= '0;
      r_shiftOp   <= OP_SRL;
    end else begin
      case (r_state)
        IDLE: begin
          r_inReady <= 1'b1;
          if (w_accept) begin
            r_inReady <= 1'b0;
            if (w_illegal) begin
              r_result    <= '0;
              r_illegal   <= 1'b1;
              r_hasResult <= 1'b1;
              r_outValid  <= 1'b1;
              r_state     <= DONE;
            end else if ((SHIFT_SERIAL != 0) && w_isShift && (w_shamt != '0)) begin
              r_shiftReg <= bus.op_a;
              r_count    <= w_shamt;
              r_shiftOp  <= w_op;
              r_state    <= SHIFT;
            end else begin
              r_result    <= w_aluResult;
              r_illegal   <= 1'b0;
              r_hasResult <= 1'b1;
              r_outValid  <= 1'b1;
              r_state     <= DONE;
            end
          end
        end
        SHIFT: begin
          r_shiftReg <= w_shiftStep;
          r_count    <= r_count - 1'b1;
          if (r_count == SHW'(1)) begin
            r_result    <= w_shiftStep;
            r_illegal   <= 1'b0;
            r_hasResult <= 1'b1;
            r_outValid  <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_inReady;
  assign bus.out_valid = r_outValid;
  assign bus.result    = r_result;
  assign bus.illegal   = r_illegal;
  // zero is suppressed until a result exists so it reads 0 out of reset
  assign bus.zero      = r_hasResult && (r_result == '0);
endmodule
